uart_tx_fifo: RTL and testbench

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

---
 rtl/uart_tx_fifo_if.sv | 13 +
 rtl/uart_tx_fifo.sv | 135 +++++++++++++
 tb/tb_uart_tx_fifo.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_fifo_if.sv
// Enqueue-side bus of the UART transmitter: word, request, not-full flag and occupancy.
interface uart_tx_fifo_if #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
);
  logic [DATA_W-1:0]      DATA;
  logic                   EN;
  logic                   READY;
  logic [$clog2(DEPTH):0] LEVEL;

  modport master (output DATA, output EN, input READY, input LEVEL);
  modport slave  (input DATA, input EN, output READY, output LEVEL);
endinterface

// File: rtl/uart_tx_fifo.sv
// UART transmitter with a small transmit FIFO; frame format and bit period are
// captured per word at pop time so mid-frame setting changes apply to the next frame.
module uart_tx_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 16
) (
  input  logic             CLK,
  input  logic             RESET,
  uart_tx_fifo_if.slave    host,
  input  logic [CNT_W-1:0] BIT_TIME,
  input  logic             PARITY_EN,
  input  logic             PARITY_ODD,
  input  logic             STOP2,
  input  logic             MSB_FIRST,
  output logic             BUSY,
  output logic             TX
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int IW = $clog2(DATA_W);

  typedef enum logic [2:0] {
    ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP1, ST_STOP2
  } state_t;

  state_t            state_reg, state_next;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr_reg, rd_ptr_reg;
  logic [LW-1:0]     count_reg;
  logic [CNT_W-1:0]  bit_cnt_reg, bit_time_reg;
  logic [IW-1:0]     data_idx_reg;
  logic [DATA_W-1:0] shift_reg;
  logic              parity_reg, parity_en_reg, stop2_reg, tx_reg;

  logic              fifo_empty, push, pop, bit_end, last_data, frame_done, cur_bit;
  logic [DATA_W-1:0] head_word, head_rev;

  assign fifo_empty = (count_reg == '0);
  assign host.READY = (count_reg < LW'(DEPTH));
  assign host.LEVEL = count_reg;
  assign push       = host.EN && host.READY;
  assign head_word  = mem[rd_ptr_reg];
  assign bit_end    = (bit_cnt_reg == bit_time_reg);
  assign last_data  = (data_idx_reg == IW'(DATA_W - 1));
  assign BUSY       = (state_reg != ST_IDLE) || !fifo_empty;
  assign TX         = tx_reg;

  // MSB-first words are stored reversed so the data phase always shifts out bit 0.
  generate
    for (genvar gi = 0; gi < DATA_W; gi++) begin : g_rev
      assign head_rev[gi] = head_word[DATA_W-1-gi];
    end
  endgenerate

  always_ff @(posedge CLK) begin
    if (push) begin
      mem[wr_ptr_reg] <= host.DATA;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_reg     <= ST_IDLE;
      tx_reg        <= 1'b1;
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      bit_cnt_reg   <= '0;
      bit_time_reg  <= '0;
      data_idx_reg  <= '0;
      shift_reg     <= '0;
      parity_reg    <= 1'b0;
      parity_en_reg <= 1'b0;
      stop2_reg     <= 1'b0;
    end else begin
      state_reg <= state_next;
      tx_reg    <= cur_bit;
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
      count_reg <= count_reg + LW'(push) - LW'(pop);
      if (state_reg == ST_IDLE || bit_end) begin
        bit_cnt_reg <= '0;
      end else begin
        bit_cnt_reg <= bit_cnt_reg + CNT_W'(1);
      end
      if (pop) begin
        shift_reg     <= MSB_FIRST ? head_rev : head_word;
        parity_reg    <= (^head_word) ^ PARITY_ODD;
        bit_time_reg  <= BIT_TIME;
        parity_en_reg <= PARITY_EN;
        stop2_reg     <= STOP2;
        data_idx_reg  <= '0;
      end else if (state_reg == ST_DATA && bit_end) begin
        shift_reg    <= shift_reg >> 1;
        data_idx_reg <= last_data ? '0 : data_idx_reg + IW'(1);
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:   if (!fifo_empty) state_next = ST_START;
      ST_START:  if (bit_end) state_next = ST_DATA;
      ST_DATA:   if (bit_end && last_data) state_next = parity_en_reg ? ST_PARITY : ST_STOP1;
      ST_PARITY: if (bit_end) state_next = ST_STOP1;
      ST_STOP1: begin
        if (bit_end) begin
          if (stop2_reg)       state_next = ST_STOP2;
          else if (fifo_empty) state_next = ST_IDLE;
          else                 state_next = ST_START;
        end
      end
      ST_STOP2:  if (bit_end) state_next = fifo_empty ? ST_IDLE : ST_START;
      default:   state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    frame_done = bit_end && ((state_reg == ST_STOP1 && !stop2_reg) || state_reg == ST_STOP2);
    pop        = !fifo_empty && (state_reg == ST_IDLE || frame_done);
    cur_bit    = 1'b1;
    case (state_reg)
      ST_START:  cur_bit = 1'b0;
      ST_DATA:   cur_bit = shift_reg[0];
      ST_PARITY: cur_bit = parity_reg;
      default:   cur_bit = 1'b1;
    endcase
  end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: randomized and directed frames checked against a
// frame-level timeline model (pop edges, frame lengths, bit patterns).
module tb_uart_tx_fifo;
  localparam int DEPTH = 4;
  localparam int MAXC  = 512;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [15:0] bit_time;
  logic        par_en, par_odd, stop2, msb;
  logic        tx8, busy8, tx5, busy5;

  uart_tx_fifo_if #(.DATA_W(8), .DEPTH(DEPTH)) bus8 ();
  uart_tx_fifo_if #(.DATA_W(5), .DEPTH(DEPTH)) bus5 ();

  uart_tx_fifo #(.DATA_W(8), .DEPTH(DEPTH), .CNT_W(16)) u8 (
    .CLK(CLK), .RESET(RESET), .host(bus8), .BIT_TIME(bit_time), .PARITY_EN(par_en),
    .PARITY_ODD(par_odd), .STOP2(stop2), .MSB_FIRST(msb), .BUSY(busy8), .TX(tx8));

  uart_tx_fifo #(.DATA_W(5), .DEPTH(DEPTH), .CNT_W(16)) u5 (
    .CLK(CLK), .RESET(RESET), .host(bus5), .BIT_TIME(bit_time), .PARITY_EN(par_en),
    .PARITY_ODD(par_odd), .STOP2(stop2), .MSB_FIRST(msb), .BUSY(busy5), .TX(tx5));

  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;

  logic [8:0] push_w [16];
  int         n_push;
  logic       exp_tx [MAXC], exp_busy [MAXC], exp_ready [MAXC];
  int         exp_level [MAXC];
  logic       obs_tx [MAXC], obs_busy [MAXC], obs_ready [MAXC];
  int         obs_level [MAXC];

  // Timeline model: frame n pops at max(push edge + 1, previous pop + previous frame length).
  function automatic void build_model(input int dw, input int ncyc, input int bt_old,
                                      input int bt_at, input int bt_new);
    int         acc_cnt, pop_cnt, next_pop, frm_end, bt, nb, idx;
    logic [8:0] acc_w [16];
    logic       bits [16];
    logic       p;
    acc_cnt = 0; pop_cnt = 0; next_pop = 0; frm_end = -1;
    for (int j = 0; j < ncyc; j++) exp_tx[j] = 1'b1;
    for (int j = 0; j < ncyc; j++) begin
      exp_ready[j] = (acc_cnt - pop_cnt) < DEPTH;
      if (pop_cnt < acc_cnt && j >= next_pop) begin
        bt = (j > bt_at) ? bt_new : bt_old;
        nb = 0;
        bits[nb] = 1'b0; nb = nb + 1;
        p = 1'b0;
        for (int i = 0; i < dw; i++) begin
          bits[nb] = msb ? acc_w[pop_cnt][dw-1-i] : acc_w[pop_cnt][i];
          nb = nb + 1;
          p = p ^ acc_w[pop_cnt][i];
        end
        if (par_en) begin bits[nb] = p ^ par_odd; nb = nb + 1; end
        bits[nb] = 1'b1; nb = nb + 1;
        if (stop2) begin bits[nb] = 1'b1; nb = nb + 1; end
        for (int b = 0; b < nb; b++)
          for (int c = 0; c <= bt; c++) begin
            idx = j + 1 + b * (bt + 1) + c;
            if (idx < ncyc) exp_tx[idx] = bits[b];
          end
        next_pop = j + nb * (bt + 1);
        frm_end  = next_pop;
        pop_cnt  = pop_cnt + 1;
      end
      if (j < n_push && exp_ready[j]) begin
        acc_w[acc_cnt] = push_w[j];
        acc_cnt = acc_cnt + 1;
      end
      exp_level[j] = acc_cnt - pop_cnt;
      exp_busy[j]  = (acc_cnt > pop_cnt) || (j < frm_end);
    end
  endfunction

  // Pushes push_w[0..n_push-1] on consecutive edges and records outputs after each edge.
  task automatic drive_run(input int dut5, input int ncyc, input int bt_at, input logic [15:0] bt_new);
    for (int j = 0; j < ncyc; j++) begin
      obs_ready[j] = dut5 != 0 ? bus5.READY : bus8.READY;
      if (j < n_push) begin
        if (dut5 != 0) begin bus5.EN = 1'b1; bus5.DATA = push_w[j][4:0]; end
        else begin bus8.EN = 1'b1; bus8.DATA = push_w[j][7:0]; end
      end else begin
        bus5.EN = 1'b0; bus8.EN = 1'b0;
      end
      @(negedge CLK);
      if (j == bt_at) bit_time = bt_new;
      obs_tx[j]    = dut5 != 0 ? tx5 : tx8;
      obs_busy[j]  = dut5 != 0 ? busy5 : busy8;
      obs_level[j] = dut5 != 0 ? int'(bus5.LEVEL) : int'(bus8.LEVEL);
    end
    bus5.EN = 1'b0; bus8.EN = 1'b0;
  endtask

  task automatic test_reset;
    RESET = 1'b1;
    bus8.EN = 1'b1; bus8.DATA = 8'h55; bus5.EN = 1'b1; bus5.DATA = 5'h15;
    repeat (3) @(negedge CLK);
    checks++; if (tx8 !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b want 1", tx8); end
    checks++; if (bus8.READY !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", bus8.READY); end
    checks++; if (bus8.LEVEL !== 3'd0) begin errors++; $display("FAIL reset_level: got %0d want 0", bus8.LEVEL); end
    checks++; if (busy8 !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy8); end
    checks++; if (tx5 !== 1'b1) begin errors++; $display("FAIL reset_tx5: got %b want 1", tx5); end
    RESET = 1'b0; bus8.EN = 1'b0; bus5.EN = 1'b0;
    repeat (3) @(negedge CLK);
    checks++; if (tx8 !== 1'b1 || busy8 !== 1'b0 || bus8.LEVEL !== 3'd0) begin
      errors++; $display("FAIL reset_en_ignored: tx=%b busy=%b level=%0d want 1/0/0", tx8, busy8, bus8.LEVEL);
    end
    $display("reset: done, EN held during reset");
  endtask

  task automatic test_basic;
    int   ncyc;
    logic seq [10] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    bit_time = 16'd3; par_en = 1'b0; par_odd = 1'b0; stop2 = 1'b0; msb = 1'b0;
    n_push = 1; push_w[0] = 9'h0A5; ncyc = 46;
    build_model(8, ncyc, 3, MAXC, 3);
    drive_run(0, ncyc, MAXC, 16'd3);
    for (int j = 0; j < ncyc; j++) begin
      checks++; if (obs_tx[j] !== exp_tx[j]) begin errors++; $display("FAIL basic_tx edge+%0d: got %b want %b", j, obs_tx[j], exp_tx[j]); end
      checks++; if (obs_level[j] != exp_level[j]) begin errors++; $display("FAIL basic_level edge+%0d: got %0d want %0d", j, obs_level[j], exp_level[j]); end
      checks++; if (obs_busy[j] !== exp_busy[j]) begin errors++; $display("FAIL basic_busy edge+%0d: got %b want %b", j, obs_busy[j], exp_busy[j]); end
    end
    checks++; if (obs_tx[1] !== 1'b1) begin errors++; $display("FAIL basic_latency_k1: got %b want 1", obs_tx[1]); end
    for (int i = 0; i < 10; i++)
      for (int c = 0; c < 4; c++) begin
        checks++;
        if (obs_tx[2 + 4*i + c] !== seq[i]) begin
          errors++; $display("FAIL basic_a5_bit%0d cyc%0d: got %b want %b", i, c, obs_tx[2 + 4*i + c], seq[i]);
        end
      end
    $display("basic: frame 0xa5 over %0d cycles", ncyc);
  endtask

  task automatic test_parity;
    int ncyc;
    bit_time = 16'd3; par_en = 1'b1; par_odd = 1'b0; stop2 = 1'b1; msb = 1'b0;
    n_push = 2; push_w[0] = 9'h007; push_w[1] = 9'h007; ncyc = 104;
    build_model(8, ncyc, 3, MAXC, 3);
    drive_run(0, ncyc, MAXC, 16'd3);
    for (int j = 0; j < ncyc; j++) begin
      checks++; if (obs_tx[j] !== exp_tx[j]) begin errors++; $display("FAIL even_tx edge+%0d: got %b want %b", j, obs_tx[j], exp_tx[j]); end
      checks++; if (obs_busy[j] !== exp_busy[j]) begin errors++; $display("FAIL even_busy edge+%0d: got %b want %b", j, obs_busy[j], exp_busy[j]); end
    end
    checks++; if (obs_tx[38] !== 1'b1) begin errors++; $display("FAIL even_parity_bit: got %b want 1", obs_tx[38]); end
    for (int c = 0; c < 8; c++) begin
      checks++; if (obs_tx[42 + c] !== 1'b1) begin errors++; $display("FAIL stop2_high cyc%0d: got %b want 1", c, obs_tx[42 + c]); end
    end
    checks++; if (obs_tx[50] !== 1'b0) begin errors++; $display("FAIL stop2_next_start: got %b want 0", obs_tx[50]); end
    $display("parity: two even/stop2 frames 0x07 over %0d cycles", ncyc);

    par_odd = 1'b1; stop2 = 1'b0; n_push = 1; ncyc = 50;
    build_model(8, ncyc, 3, MAXC, 3);
    drive_run(0, ncyc, MAXC, 16'd3);
    for (int j = 0; j < ncyc; j++) begin
      checks++; if (obs_tx[j] !== exp_tx[j]) begin errors++; $display("FAIL odd_tx edge+%0d: got %b want %b", j, obs_tx[j], exp_tx[j]); end
    end
    checks++; if (obs_tx[38] !== 1'b0) begin errors++; $display("FAIL odd_parity_bit: got %b want 0", obs_tx[38]); end
    $display("parity: odd frame 0x07 over %0d cycles", ncyc);
    par_en = 1'b0; par_odd = 1'b0;
  endtask

  task automatic test_back_to_back;
    int bt, ncyc;
    bt = int'($urandom_range(0, 2));
    bit_time = 16'(bt); par_en = 1'($urandom); par_odd = 1'($urandom);
    stop2 = 1'($urandom); msb = 1'($urandom);
    n_push = 6;
    for (int i = 0; i < 6; i++) push_w[i] = 9'($urandom_range(0, 255));
    ncyc = 6 * 13 * (bt + 1) + 8;
    build_model(8, ncyc, bt, MAXC, bt);
    drive_run(0, ncyc, MAXC, 16'(bt));
    for (int j = 0; j < ncyc; j++) begin
      checks++; if (obs_tx[j] !== exp_tx[j]) begin errors++; $display("FAIL b2b_tx edge+%0d: got %b want %b", j, obs_tx[j], exp_tx[j]); end
      checks++; if (obs_level[j] != exp_level[j]) begin errors++; $display("FAIL b2b_level edge+%0d: got %0d want %0d", j, obs_level[j], exp_level[j]); end
      checks++; if (obs_busy[j] !== exp_busy[j]) begin errors++; $display("FAIL b2b_busy edge+%0d: got %b want %b", j, obs_busy[j], exp_busy[j]); end
      checks++; if (obs_ready[j] !== exp_ready[j]) begin errors++; $display("FAIL b2b_ready edge+%0d: got %b want %b", j, obs_ready[j], exp_ready[j]); end
    end
    checks++; if (obs_ready[4] !== 1'b1) begin errors++; $display("FAIL b2b_ready_before5: got %b want 1", obs_ready[4]); end
    checks++; if (obs_ready[5] !== 1'b0) begin errors++; $display("FAIL b2b_ready_full: got %b want 0", obs_ready[5]); end
    checks++; if (obs_busy[ncyc-1] !== 1'b0) begin errors++; $display("FAIL b2b_busy_end: got %b want 0", obs_busy[ncyc-1]); end
    $display("back_to_back: 6 pushes bt=%0d par=%b stop2=%b msb=%b over %0d cycles", bt, par_en, stop2, msb, ncyc);
    par_en = 1'b0; par_odd = 1'b0; stop2 = 1'b0; msb = 1'b0;
  endtask

  task automatic test_msb5;
    int   ncyc;
    logic seq [7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    bit_time = 16'd0; par_en = 1'b0; stop2 = 1'b0; msb = 1'b1;
    n_push = 1; push_w[0] = 9'b000010011; ncyc = 13;
    build_model(5, ncyc, 0, MAXC, 0);
    drive_run(1, ncyc, MAXC, 16'd0);
    for (int j = 0; j < ncyc; j++) begin
      checks++; if (obs_tx[j] !== exp_tx[j]) begin errors++; $display("FAIL msb5_tx edge+%0d: got %b want %b", j, obs_tx[j], exp_tx[j]); end
      checks++; if (obs_busy[j] !== exp_busy[j]) begin errors++; $display("FAIL msb5_busy edge+%0d: got %b want %b", j, obs_busy[j], exp_busy[j]); end
    end
    for (int i = 0; i < 7; i++) begin
      checks++; if (obs_tx[2 + i] !== seq[i]) begin errors++; $display("FAIL msb5_bit%0d: got %b want %b", i, obs_tx[2 + i], seq[i]); end
    end
    $display("msb5: frame 5'b10011 msb-first over %0d cycles", ncyc);
    msb = 1'b0;
  endtask

  task automatic test_bit_time_change;
    int ncyc;
    bit_time = 16'd3; par_en = 1'b0; stop2 = 1'b0; msb = 1'b0;
    n_push = 2; push_w[0] = 9'($urandom_range(0, 255)); push_w[1] = 9'($urandom_range(0, 255));
    ncyc = 148;
    build_model(8, ncyc, 3, 10, 9);
    drive_run(0, ncyc, 10, 16'd9);
    for (int j = 0; j < ncyc; j++) begin
      checks++; if (obs_tx[j] !== exp_tx[j]) begin errors++; $display("FAIL btchg_tx edge+%0d: got %b want %b", j, obs_tx[j], exp_tx[j]); end
      checks++; if (obs_busy[j] !== exp_busy[j]) begin errors++; $display("FAIL btchg_busy edge+%0d: got %b want %b", j, obs_busy[j], exp_busy[j]); end
    end
    for (int c = 0; c < 10; c++) begin
      checks++; if (obs_tx[42 + c] !== 1'b0) begin errors++; $display("FAIL btchg_start10 cyc%0d: got %b want 0", c, obs_tx[42 + c]); end
    end
    checks++; if (obs_tx[41] !== 1'b1) begin errors++; $display("FAIL btchg_stop4: got %b want 1", obs_tx[41]); end
    $display("bit_time_change: frames 0x%02h/0x%02h bt 3->9 over %0d cycles", push_w[0][7:0], push_w[1][7:0], ncyc);
    bit_time = 16'd3;
  endtask

  task automatic test_random;
    int bt, ncyc;
    for (int it = 0; it < 8; it++) begin
      bt = int'($urandom_range(0, 3));
      bit_time = 16'(bt); par_en = 1'($urandom); par_odd = 1'($urandom);
      stop2 = 1'($urandom); msb = 1'($urandom);
      n_push = int'($urandom_range(1, 3));
      for (int i = 0; i < n_push; i++) push_w[i] = 9'($urandom_range(0, 255));
      ncyc = n_push * 13 * (bt + 1) + 8;
      build_model(8, ncyc, bt, MAXC, bt);
      drive_run(0, ncyc, MAXC, 16'(bt));
      for (int j = 0; j < ncyc; j++) begin
        checks++; if (obs_tx[j] !== exp_tx[j]) begin errors++; $display("FAIL rand%0d_tx edge+%0d: got %b want %b", it, j, obs_tx[j], exp_tx[j]); end
        checks++; if (obs_level[j] != exp_level[j]) begin errors++; $display("FAIL rand%0d_level edge+%0d: got %0d want %0d", it, j, obs_level[j], exp_level[j]); end
        checks++; if (obs_busy[j] !== exp_busy[j]) begin errors++; $display("FAIL rand%0d_busy edge+%0d: got %b want %b", it, j, obs_busy[j], exp_busy[j]); end
      end
      $display("random %0d: %0d words first=0x%02h bt=%0d par=%b odd=%b stop2=%b msb=%b", it, n_push, push_w[0][7:0], bt, par_en, par_odd, stop2, msb);
    end
    par_en = 1'b0; par_odd = 1'b0; stop2 = 1'b0; msb = 1'b0;
  endtask

  task automatic test_reset_mid;
    int ncyc;
    bit_time = 16'd3; par_en = 1'b0; stop2 = 1'b0; msb = 1'b0;
    n_push = 3;
    for (int i = 0; i < 3; i++) push_w[i] = 9'($urandom_range(0, 255));
    ncyc = 16;
    build_model(8, ncyc, 3, MAXC, 3);
    drive_run(0, ncyc, MAXC, 16'd3);
    for (int j = 0; j < ncyc; j++) begin
      checks++; if (obs_tx[j] !== exp_tx[j]) begin errors++; $display("FAIL rstmid_tx edge+%0d: got %b want %b", j, obs_tx[j], exp_tx[j]); end
      checks++; if (obs_level[j] != exp_level[j]) begin errors++; $display("FAIL rstmid_level edge+%0d: got %0d want %0d", j, obs_level[j], exp_level[j]); end
    end
    RESET = 1'b1; bus8.EN = 1'b1; bus8.DATA = 8'h3C;
    @(negedge CLK);
    checks++; if (tx8 !== 1'b1) begin errors++; $display("FAIL rstmid_tx_after: got %b want 1", tx8); end
    checks++; if (bus8.LEVEL !== 3'd0) begin errors++; $display("FAIL rstmid_level_after: got %0d want 0", bus8.LEVEL); end
    checks++; if (busy8 !== 1'b0) begin errors++; $display("FAIL rstmid_busy_after: got %b want 0", busy8); end
    checks++; if (bus8.READY !== 1'b1) begin errors++; $display("FAIL rstmid_ready_after: got %b want 1", bus8.READY); end
    RESET = 1'b0; bus8.EN = 1'b0;
    for (int j = 0; j < 60; j++) begin
      @(negedge CLK);
      checks++;
      if (tx8 !== 1'b1 || busy8 !== 1'b0) begin
        errors++; $display("FAIL rstmid_quiet cyc%0d: tx=%b busy=%b want 1/0", j, tx8, busy8);
      end
    end
    $display("reset_mid: aborted frame with 2 queued words");
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    RESET = 1'b1; bit_time = 16'd3;
    par_en = 1'b0; par_odd = 1'b0; stop2 = 1'b0; msb = 1'b0;
    bus8.EN = 1'b0; bus8.DATA = '0; bus5.EN = 1'b0; bus5.DATA = '0;
    n_push = 0;
    @(negedge CLK);
    test_reset();
    test_basic();
    test_parity();
    test_back_to_back();
    test_msb5();
    test_bit_time_change();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
